// File: rtl/cu_read_eeprom.sv
// cu_read_eeprom
//   Reads one EEPROM page into the on-chip page buffer through the shared
//   SPI byte master. Each page transaction sends the READ opcode and the
//   byte address (MSB first), then clocks dummy bytes. Every byte received
//   during the data phase is written to the buffer at an incrementing address.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start_pulse      request to read a page (accepted only while idle)
//   page_addr        page number, byte address = {page_addr, 8'h00}
//   spi_done         SPI master finished the current byte exchange
//   spi_rx_data      byte received by the SPI master (valid with spi_done)
//   load_data        start the SPI master on tx_data
//   tx_data          byte to transmit (opcode / address / dummy)
//   nCS              EEPROM chip select, active low
//   addr, buf_we,
//   buf_wdata        page buffer write port
//   busy             controller is not idle
//   page_done        pulse after the last data byte reached the buffer
module cu_read_eeprom #(
  parameter int unsigned PAGE_BYTES     = 256,
  parameter logic [7:0]  CMD_READ       = 8'h03,
  parameter int unsigned ADDR_BYTES     = 3,
  parameter int unsigned CS_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_pulse,
  input  logic [15:0] page_addr,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx_data,
  output logic        load_data,
  output logic [7:0]  tx_data,
  output logic        nCS,
  output logic [7:0]  addr,
  output logic        buf_we,
  output logic [7:0]  buf_wdata,
  output logic        busy,
  output logic        page_done
);

  localparam int unsigned HW = $clog2(ADDR_BYTES + 1);
  localparam int unsigned CW = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam int unsigned AW = ADDR_BYTES * 8;

  localparam logic [HW-1:0] HDR_LAST  = HW'(ADDR_BYTES);
  localparam logic [8:0]    BYTE_LAST = 9'(PAGE_BYTES - 1);
  localparam logic [CW-1:0] CS_LAST   = CW'(CS_HIGH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_ASSERT,
    HDR_LOAD,
    HDR_WAIT,
    DAT_LOAD,
    DAT_WAIT,
    STORE,
    CS_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   page_addr_q, page_addr_d;
  logic [HW-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [8:0]    byte_cnt_q, byte_cnt_d;
  logic [CW-1:0] cs_cnt_q, cs_cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          load_data_q, load_data_d;
  logic          ncs_q, ncs_d;
  logic [7:0]    addr_q, addr_d;
  logic          buf_we_q, buf_we_d;
  logic [7:0]    buf_wdata_q, buf_wdata_d;
  logic          page_done_q, page_done_d;

  // Address byte for the next header slot. Header slot k (1..ADDR_BYTES)
  // carries byte_addr[(ADDR_BYTES-k)*8 +: 8], i.e. MSB first.
  logic [AW-1:0] byte_addr;
  logic [HW-1:0] hdr_next;
  logic [HW-1:0] hdr_sel;
  logic [7:0]    hdr_byte;

  assign byte_addr = AW'({page_addr_q, 8'h00});
  assign hdr_next  = hdr_cnt_q + 1'b1;
  assign hdr_sel   = HDR_LAST - hdr_next;
  assign hdr_byte  = 8'(byte_addr >> {hdr_sel, 3'b000});

  // Outputs are registered; load_data/tx_data are set on entry to a *_LOAD
  // state so the strobe is exactly the one cycle spent in that state.
  always_comb begin
    state_d     = state_q;
    page_addr_d = page_addr_q;
    hdr_cnt_d   = hdr_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    cs_cnt_d    = cs_cnt_q;
    tx_data_d   = tx_data_q;
    ncs_d       = ncs_q;
    addr_d      = addr_q;
    buf_wdata_d = buf_wdata_q;
    load_data_d = 1'b0;
    buf_we_d    = 1'b0;
    page_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        ncs_d = 1'b1;
        if (start_pulse) begin
          page_addr_d = page_addr;
          hdr_cnt_d   = '0;
          byte_cnt_d  = '0;
          state_d     = CS_ASSERT;
        end
      end
      CS_ASSERT: begin
        ncs_d       = 1'b0;
        tx_data_d   = CMD_READ;
        load_data_d = 1'b1;
        state_d     = HDR_LOAD;
      end
      HDR_LOAD: state_d = HDR_WAIT;
      HDR_WAIT: begin
        if (spi_done) begin
          load_data_d = 1'b1;
          if (hdr_cnt_q == HDR_LAST) begin
            tx_data_d = 8'h00;
            state_d   = DAT_LOAD;
          end else begin
            hdr_cnt_d = hdr_next;
            tx_data_d = hdr_byte;
            state_d   = HDR_LOAD;
          end
        end
      end
      DAT_LOAD: state_d = DAT_WAIT;
      DAT_WAIT: begin
        if (spi_done) begin
          buf_wdata_d = spi_rx_data;
          addr_d      = byte_cnt_q[7:0];
          buf_we_d    = 1'b1;
          state_d     = STORE;
        end
      end
      STORE: begin
        if (byte_cnt_q == BYTE_LAST) begin
          page_done_d = 1'b1;
          ncs_d       = 1'b1;
          cs_cnt_d    = '0;
          state_d     = CS_RELEASE;
        end else begin
          byte_cnt_d  = byte_cnt_q + 9'd1;
          tx_data_d   = 8'h00;
          load_data_d = 1'b1;
          state_d     = DAT_LOAD;
        end
      end
      CS_RELEASE: begin
        if (cs_cnt_q == CS_LAST) begin
          state_d = IDLE;
        end else begin
          cs_cnt_d = cs_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      page_addr_q <= '0;
      hdr_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      cs_cnt_q    <= '0;
      tx_data_q   <= '0;
      load_data_q <= 1'b0;
      ncs_q       <= 1'b1;
      addr_q      <= '0;
      buf_we_q    <= 1'b0;
      buf_wdata_q <= '0;
      page_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      page_addr_q <= page_addr_d;
      hdr_cnt_q   <= hdr_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      cs_cnt_q    <= cs_cnt_d;
      tx_data_q   <= tx_data_d;
      load_data_q <= load_data_d;
      ncs_q       <= ncs_d;
      addr_q      <= addr_d;
      buf_we_q    <= buf_we_d;
      buf_wdata_q <= buf_wdata_d;
      page_done_q <= page_done_d;
    end
  end

  assign load_data = load_data_q;
  assign tx_data   = tx_data_q;
  assign nCS       = ncs_q;
  assign addr      = addr_q;
  assign buf_we    = buf_we_q;
  assign buf_wdata = buf_wdata_q;
  assign page_done = page_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cu_read_eeprom.sv
// Bench for cu_read_eeprom: SPI slave model with a scoreboard of expected
// buffer writes, table of page reads, plus reset/abort/back-to-back sequences.
module tb_cu_read_eeprom;

  localparam int CS_HIGH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_pulse;
  logic [15:0] page_addr;
  logic        spi_done;
  logic [7:0]  spi_rx_data;
  logic        load_data;
  logic [7:0]  tx_data;
  logic        nCS;
  logic [7:0]  addr;
  logic        buf_we;
  logic [7:0]  buf_wdata;
  logic        busy;
  logic        page_done;

  cu_read_eeprom #(
    .PAGE_BYTES(256), .CMD_READ(8'h03), .ADDR_BYTES(3), .CS_HIGH_CYCLES(CS_HIGH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .page_addr(page_addr),
    .spi_done(spi_done), .spi_rx_data(spi_rx_data), .load_data(load_data),
    .tx_data(tx_data), .nCS(nCS), .addr(addr), .buf_we(buf_we),
    .buf_wdata(buf_wdata), .busy(busy), .page_done(page_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] page;
    logic [7:0]  key;
    int          delay;
    logic        glitch;
    logic [7:0]  h1;
    logic [7:0]  h2;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // shared state between main, SPI model and monitor
  logic [7:0]  key;
  int          spi_delay;
  logic        glitch_en;
  logic        idle_pulse;
  logic [7:0]  tx_log[$];
  logic [15:0] sb[$];
  int          we_cnt;
  int          pd_cnt;
  int          first_addr;
  int          hi_run;
  int          last_gap;
  logic        prev_ld;
  logic        seen_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait expired", name);
  endtask

  // SPI slave model: answers every load_data after spi_delay clocks.
  initial begin : spi_model
    int cnt;
    int ld_idx;
    int cur_idx;
    int di;
    spi_done = 1'b0;
    spi_rx_data = 8'h00;
    cnt = 0;
    ld_idx = 0;
    cur_idx = 0;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (nCS) ld_idx = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          spi_done = 1'b1;
          if (cur_idx >= 4) begin
            di = cur_idx - 4;
            spi_rx_data = 8'(di) ^ key;
            sb.push_back({8'(di), 8'(di) ^ key});
          end else begin
            spi_rx_data = 8'($urandom);
          end
        end
      end
      if (load_data) begin
        tx_log.push_back(tx_data);
        cur_idx = ld_idx;
        ld_idx++;
        cnt = spi_delay;
        if (glitch_en && cur_idx >= 4) spi_done = 1'b1;
      end else if (idle_pulse && !busy) begin
        spi_done = 1'b1;
        idle_pulse = 1'b0;
      end
    end
  end

  // Monitor: scoreboard compare on buf_we, protocol invariants.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n) begin
      if (load_data) begin
        check("load_not_back_to_back", {31'd0, prev_ld}, 32'd0);
        check("ncs_low_on_load", {31'd0, nCS}, 32'd0);
      end
      prev_ld = load_data;
      if (buf_we) begin
        check("ncs_low_on_we", {31'd0, nCS}, 32'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_buf_we: addr %0h data %0h with empty scoreboard", addr, buf_wdata);
        end else begin
          e = sb.pop_front();
          check("we_addr", {24'd0, addr}, {24'd0, e[15:8]});
          check("we_data", {24'd0, buf_wdata}, {24'd0, e[7:0]});
        end
        if (we_cnt == 0) first_addr = int'(addr);
        we_cnt++;
      end
      if (page_done) begin
        pd_cnt++;
        seen_done = 1'b1;
      end
      if (nCS) begin
        hi_run++;
      end else begin
        if (hi_run > 0 && seen_done) begin
          last_gap = hi_run;
          check("cs_high_gap", {31'd0, (hi_run >= CS_HIGH)}, 32'd1);
        end
        hi_run = 0;
      end
    end else begin
      prev_ld = 1'b0;
      hi_run = 0;
    end
  end

  task automatic launch(input vec_t v);
    tx_log.delete();
    we_cnt = 0;
    pd_cnt = 0;
    key = v.key;
    spi_delay = v.delay;
    glitch_en = v.glitch;
    page_addr = v.page;
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    page_addr = 16'h0000;
  endtask

  task automatic wait_writes(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      @(negedge clk);
      if (we_cnt >= n) ok = 1'b1;
    end
  endtask

  task automatic finish_page(input vec_t v);
    bit seen;
    int nz;
    seen = 1'b0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge clk);
      if (page_done) seen = 1'b1;
    end
    if (!seen) begin
      timeout_fail("page_done_timeout");
      return;
    end
    check("ncs_high_at_done", {31'd0, nCS}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("page_done_one_cycle", {31'd0, page_done}, 32'd0);
    check("ncs_high_release", {31'd0, nCS}, 32'd1);
    check("busy_in_release", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("idle_after_release", {31'd0, busy}, 32'd0);
    check("write_count", we_cnt, 256);
    check("page_done_count", pd_cnt, 1);
    check("scoreboard_drained", sb.size(), 0);
    check("load_count", tx_log.size(), 260);
    if (tx_log.size() >= 4) begin
      check("hdr_cmd", {24'd0, tx_log[0]}, 32'h03);
      check("hdr_a23_16", {24'd0, tx_log[1]}, {24'd0, v.h1});
      check("hdr_a15_8", {24'd0, tx_log[2]}, {24'd0, v.h2});
      check("hdr_a7_0", {24'd0, tx_log[3]}, 32'h00);
    end
    nz = 0;
    for (int k = 4; k < tx_log.size(); k++) if (tx_log[k] != 8'h00) nz++;
    check("dummy_bytes_zero", nz, 0);
    $display("page %04h key %02h delay %0d: writes=%0d page_done=%0d loads=%0d",
             v.page, v.key, v.delay, we_cnt, pd_cnt, tx_log.size());
  endtask

  initial begin : main
    vec_t vecs[3];
    bit   ok;
    int   ld_seen;

    vecs[0] = '{page: 16'h12A5, key: 8'h5A, delay: 8, glitch: 1'b0, h1: 8'h12, h2: 8'hA5};
    vecs[1] = '{page: 16'hFF00, key: 8'hC3, delay: 3, glitch: 1'b1, h1: 8'hFF, h2: 8'h00};
    vecs[2] = '{page: 16'h0001, key: 8'h00, delay: 2, glitch: 1'b0, h1: 8'h00, h2: 8'h01};

    rst_n = 1'b0;
    start_pulse = 1'b0;
    page_addr = 16'h0000;
    key = 8'h00;
    spi_delay = 2;
    glitch_en = 1'b0;
    idle_pulse = 1'b0;
    we_cnt = 0;
    pd_cnt = 0;
    first_addr = -1;
    hi_run = 0;
    last_gap = 0;
    prev_ld = 1'b0;
    seen_done = 1'b0;

    // reset held: start_pulse toggling must have no effect
    ld_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start_pulse = ~start_pulse;
      page_addr = 16'($urandom);
      if (load_data) ld_seen++;
    end
    check("rst_ncs", {31'd0, nCS}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {24'd0, addr}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_buf_we", {31'd0, buf_we}, 32'd0);
    check("rst_page_done", {31'd0, page_done}, 32'd0);
    check("rst_no_load", ld_seen, 0);
    start_pulse = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_without_start", {31'd0, busy}, 32'd0);
    $display("reset sequence: ncs=%0d busy=%0d", nCS, busy);

    // table of page reads
    for (int i = 0; i < 3; i++) begin
      launch(vecs[i]);
      if (vecs[i].glitch) begin
        wait_writes(50, ok);
        if (!ok) timeout_fail("wait_50_writes");
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
          @(negedge clk);
          if (load_data) ok = 1'b1;
        end
        if (!ok) timeout_fail("wait_dat_load");
        @(negedge clk);
        start_pulse = 1'b1;
        page_addr = 16'hDEAD;
        @(negedge clk);
        start_pulse = 1'b0;
        page_addr = 16'h0000;
      end
      finish_page(vecs[i]);
      if (vecs[i].glitch) begin
        glitch_en = 1'b0;
        idle_pulse = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_spi_done_ignored_we", we_cnt, 256);
        check("idle_spi_done_ignored_busy", {31'd0, busy}, 32'd0);
        $display("ignored stimulus: writes=%0d busy=%0d", we_cnt, busy);
      end
    end

    // abort after data byte 100
    launch(vecs[2]);
    wait_writes(101, ok);
    if (!ok) timeout_fail("wait_101_writes");
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ncs_async", {31'd0, nCS}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_buf_we", {31'd0, buf_we}, 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    sb.delete();
    check("abort_no_page_done", pd_cnt, 0);
    $display("abort: writes before reset=%0d page_done=%0d", we_cnt, pd_cnt);
    first_addr = -1;
    launch(vecs[0]);
    finish_page(vecs[0]);
    check("restart_first_addr", first_addr, 0);

    // back-to-back: start in the first idle cycle after a page
    launch(vecs[2]);
    finish_page(vecs[2]);
    launch(vecs[1]);
    check("b2b_accepted", {31'd0, busy}, 32'd1);
    finish_page(vecs[1]);
    check("b2b_gap", {31'd0, (last_gap >= CS_HIGH)}, 32'd1);
    $display("back-to-back: ncs high gap=%0d", last_gap);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
